// File: rtl/dct_transpose_buffer_pkg.sv
// Shared 2D-DCT definitions: block geometry, word/index types and the
// row-major <-> column-major index swap used by both DCT stages.
package dct_transpose_buffer_pkg;

  localparam int DCT_DATA_W = 16;
  localparam int DCT_LOG2N  = 3;
  localparam int DCT_N      = 1 << DCT_LOG2N;
  localparam int DCT_DEPTH  = DCT_N * DCT_N;
  localparam int DCT_AW     = 2 * DCT_LOG2N;

  typedef logic [DCT_AW-1:0] dct_idx_t;

  // Swap the row and column fields of a block index: {i[2:0], i[5:3]}.
  function automatic dct_idx_t col_major_idx(input dct_idx_t i);
    return {i[DCT_LOG2N-1:0], i[DCT_AW-1:DCT_LOG2N]};
  endfunction

endpackage

// File: rtl/dct_tb_bank.sv
// One N*N x DATA_W storage bank with a synchronous write port and a
// combinational read port. Contents are intentionally not reset.
module dct_tb_bank
  import dct_transpose_buffer_pkg::*;
#(
  parameter int DATA_W = DCT_DATA_W,
  parameter int DEPTH  = DCT_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Store the incoming word when this bank is the active write bank.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/dct_transpose_buffer.sv
// Ping-pong transpose buffer between the row-DCT and column-DCT stages.
// One bank is filled in row-major order while the other is drained in
// column-major order; full[] tracks which banks hold a complete block.
module dct_transpose_buffer
  import dct_transpose_buffer_pkg::*;
#(
  parameter int DATA_W = DCT_DATA_W
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [DCT_AW-1:0] out_idx,
  output logic              out_last
);

  localparam int            AW       = DCT_AW;
  localparam logic [AW-1:0] LAST_IDX = AW'(DCT_DEPTH - 1);

  logic [AW-1:0] wcnt_q, wcnt_d;
  logic [AW-1:0] rcnt_q, rcnt_d;
  logic          wsel_q, wsel_d;
  logic          rsel_q, rsel_d;
  logic [1:0]    full_q, full_d;

  logic          wr_fire;
  logic          rd_fire;
  logic [AW-1:0] rd_addr;
  logic [DATA_W-1:0] bank_rdata [2];

  // Handshake qualifiers and the transposed read address.
  always_comb begin
    in_ready  = !full_q[wsel_q];
    out_valid = full_q[rsel_q];
    wr_fire   = in_valid && in_ready;
    rd_fire   = out_valid && out_ready;
    rd_addr   = col_major_idx(rcnt_q);
  end

  // Two identical banks; only the selected one is written, both are read
  // at the same address and the output mux picks rsel.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
      dct_tb_bank #(
        .DATA_W (DATA_W),
        .DEPTH  (DCT_DEPTH)
      ) u_bank (
        .clk   (clk),
        .we    (wr_fire && (wsel_q == 1'(gi))),
        .waddr (wcnt_q),
        .wdata (in_data),
        .raddr (rd_addr),
        .rdata (bank_rdata[gi])
      );
    end
  endgenerate

  // Counter, bank-select and full-flag updates. A set and a clear can never
  // hit the same full bit: writing needs the bank empty, reading needs it full.
  always_comb begin
    wcnt_d = wcnt_q;
    wsel_d = wsel_q;
    rcnt_d = rcnt_q;
    rsel_d = rsel_q;
    full_d = full_q;
    if (wr_fire) begin
      wcnt_d = wcnt_q + AW'(1);
      if (wcnt_q == LAST_IDX) begin
        full_d[wsel_q] = 1'b1;
        wsel_d         = ~wsel_q;
      end
    end
    if (rd_fire) begin
      rcnt_d = rcnt_q + AW'(1);
      if (rcnt_q == LAST_IDX) begin
        full_d[rsel_q] = 1'b0;
        rsel_d         = ~rsel_q;
      end
    end
  end

  // State registers; reset abandons any partial block on either side.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      wcnt_q <= '0;
      rcnt_q <= '0;
      wsel_q <= 1'b0;
      rsel_q <= 1'b0;
      full_q <= 2'b00;
    end else begin
      wcnt_q <= wcnt_d;
      rcnt_q <= rcnt_d;
      wsel_q <= wsel_d;
      rsel_q <= rsel_d;
      full_q <= full_d;
    end
  end

  // Output word, its source index and end-of-block flag, zeroed when idle.
  always_comb begin
    out_data = '0;
    out_idx  = '0;
    out_last = 1'b0;
    if (out_valid) begin
      out_data = bank_rdata[rsel_q];
      out_idx  = rd_addr;
      out_last = (rcnt_q == LAST_IDX);
    end
  end

endmodule
